fp_add_responder: RTL
=====================

# fp_add_responder

Multi-cycle IEEE-754 floating-point adder/subtractor that serves the add-request handshake issued by `FP_Divider` (its `DivToAddA/B/Op/Load` outputs and `AddValid/AddOut` inputs). It accepts one operation per request, computes A + B or A − B with round-to-nearest-even, and returns a held result with a level `Valid` flag. The block replaces the behavioural adder model the divider has been verified against. It is the responder end of that protocol.

## Interface

Parameters:
- `PRECISION`, 32: 32 (E=8, M=23) or 64 (E=11, M=52); all widths below are derived from it.

Ports:
- `Clk`  in  1  clock; all state updates on the rising edge.
- `Rst_n`  in  1  reset; synchronous and active-low (sampled on the `Clk` rising edge).
- `A`  in  PRECISION  first operand (divider's `DivToAddA`).
- `B`  in  PRECISION  second operand (divider's `DivToAddB`).
- `Op`  in  1  0 = A+B, 1 = A−B (divider's `DivToAddOp`).
- `Load`  in  1  request strobe (divider's `DivToAddLoad`). Only its rising edge is significant.
- `Result`  out  PRECISION  rounded result (to divider's `AddOut`). Held until overwritten.
- `Valid`  out  1  result-ready level (to divider's `AddValid`).

## Operation

- **Request acceptance:**
  - A registered copy `Load_q` detects the rising edge: `Load & ~Load_q`.
  - A request is accepted only in state IDLE. `A`, `B` and `Op` are captured on that edge; B's sign is inverted when `Op`=1.
  - `Load` held high for several cycles starts exactly one operation.
  - Rising edges outside IDLE are ignored and not queued.
- **States:** IDLE → ALIGN → ADD → NORM → ROUND → IDLE, one cycle each, unconditional after acceptance.
  - **IDLE:** waits for a request.
  - **ALIGN:** unpacks operands.
    - Hidden bit = 1 for normals, 0 for subnormals.
    - A subnormal's effective exponent is 1.
    - Operands are ordered by magnitude.
    - The smaller significand is shifted right by the exponent difference into an (M+5)-bit datapath: carry, hidden, M fraction, guard, round, sticky. The sticky bit ORs all shifted-out bits.
    - Shift amounts ≥ M+4 leave only sticky.
  - **ADD:** adds the significands if signs are equal, otherwise subtracts smaller from larger. Result sign = sign of the larger magnitude.
  - **NORM:**
    - On carry out: shift right 1 (sticky preserved) and increment the exponent.
    - Otherwise: shift left by the leading-zero count, limited so the exponent does not fall below 1. Any remaining hidden bit of 0 means a subnormal result (encoded exponent 0).
  - **ROUND:** round to nearest even using guard/round/sticky.
    - Mantissa overflow from rounding increments the exponent.
    - Exponent reaching all-ones gives ±Inf.
    - `Result` is written and `Valid` set.
- **Special cases** are resolved in ALIGN, carried through the pipeline, and take the same latency:
  - Either operand NaN: canonical NaN `0_1…1_1…1` (positive sign, all-ones mantissa).
  - Inf − Inf (effective opposite signs): canonical NaN.
  - Inf ± finite: that Inf. Inf + Inf with the same sign: that Inf.
  - Exact zero sum: +0, except −0 + −0 = −0 (after `Op` inversion).
  - Zero ± x: x exactly (no rounding).
- **Reset** (`Rst_n`=0 at an edge): state = IDLE, `Result` = 0, `Valid` = 0, `Load_q` = 0. An in-flight operation is discarded.
  - If `Load` is still high when reset releases, no request is started; the next rising edge of `Load` is required.

## Timing

- Acceptance edge N:
  - `Valid` ← 0 at edge N (low from the next cycle).
  - Edges N+1, N+2 and N+3 advance ALIGN, ADD and NORM.
  - At edge N+4, ROUND writes `Result` and sets `Valid` ← 1.
- **Latency:** 4 cycles from the acceptance edge to `Valid` high, fixed for all operand values.
- The earliest next acceptance is edge N+5.
- `Valid` and `Result` stay stable until the next acceptance or reset. `Result` keeps its previous value while `Valid` is low.
- `Op` inversion and all inputs are sampled only at the acceptance edge. Input changes afterwards do not affect the in-flight operation.

## Test plan

- **Basic add:** `A`=0x3FC00000, `B`=0x3FC00000, `Op`=0, `Load` pulsed 1 cycle → `Valid` falls the cycle after acceptance; 4 cycles after acceptance `Valid`=1 and `Result`=0x40400000. `Load` held 3 cycles → exactly one operation.
- **Cancellation and signed zero:**
  - 0x3F800000 − 0x3F800000 → 0x00000000.
  - 0x80000000 + 0x80000000 → 0x80000000.
  - 0x7F800000 − 0x7F800000 → 0x7FFFFFFF.
  - 0x7FC00001 + 0x3F800000 → 0x7FFFFFFF.
- **Rounding:**
  - 0x3F800000 + 0x33800000 (tie) → 0x3F800000.
  - 0x3F800000 + 0x33C00000 → 0x3F800001.
  - 0x3F800000 − 0x33800000 → 0x3F7FFFFF.
- **Overflow and subnormals:**
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000.
  - 0x00800000 − 0x00400000 → 0x00400000.
  - 0x00000001 + 0x00000001 → 0x00000002.
- **Protocol edge cases:**
  - A second `Load` edge 2 cycles after acceptance is ignored; `Result` is the first operation's.
  - Assert `Rst_n`=0 at cycle N+2 → `Valid`=0 and `Result`=0 after that edge; no `Valid` follows.
- **Divider integration:** connect to `FP_Divider` (PRECISION 32) and run 1/2, 100/50, 0.0005/0.00005, 100/1e-37 and NaN/Inf/zero cases → every `DivResult` equals the IEEE single-precision quotient bit-for-bit.

Source files
------------

// File: rtl/fp_add_responder.sv
// Multi-cycle IEEE-754 adder/subtractor serving the divider's add-request handshake.
// One operation per Load rising edge; the result is held with a level Valid flag.
module fp_add_responder #(
    parameter int PRECISION = 32
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic [PRECISION-1:0] A,
    input  logic [PRECISION-1:0] B,
    input  logic                 Op,
    input  logic                 Load,
    output logic [PRECISION-1:0] Result,
    output logic                 Valid
);
    localparam int E  = (PRECISION == 64) ? 11 : 8;
    localparam int M  = (PRECISION == 64) ? 52 : 23;
    localparam int W  = M + 5;
    localparam int XW = E + 2;
    localparam logic [PRECISION-1:0] QNAN = {1'b0, {(PRECISION-1){1'b1}}};
    localparam logic [E-1:0]         EMAX = '1;

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND} state_t;

    state_t               state_q;
    logic                 load_q, armed_q;
    logic [PRECISION-1:0] a_q, b_q;
    logic                 sign_q, sub_q, special_q;
    logic [PRECISION-1:0] specVal_q;
    logic [XW-1:0]        exp_q;
    logic [W-1:0]         sig_q, small_q;
    logic [PRECISION-1:0] result_q;
    logic                 valid_q;

    logic                 nanA, nanB, infA, infB, zeroA, zeroB, aBigger;
    logic [E-1:0]         expBig, expSml, effBig, effSml, shAmt;
    logic [W-1:0]         bigExt, smlExt, lostMask;
    logic                 sign_d, special_d;
    logic [PRECISION-1:0] specVal_d;
    logic [W-1:0]         small_d, sum_d, normSig_d;
    logic [XW-1:0]        normExp_d, lz, maxSh, normSh, rExp, encExp;
    logic                 up;
    logic [M+1:0]         mant;
    logic [M-1:0]         frac;
    logic [PRECISION-1:0] round_d;

    assign Result = result_q;
    assign Valid  = valid_q;

    function automatic logic [XW-1:0] leadZeros(input logic [W-2:0] v);
        logic [XW-1:0] n;
        logic          found;
        n     = '0;
        found = 1'b0;
        for (int i = W - 2; i >= 0; i--) begin
            if (v[i]) found = 1'b1;
            else if (!found) n = n + 1'b1;
        end
        return n;
    endfunction

    // Unpack, classify, order by magnitude and align the smaller significand.
    always_comb begin
        nanA  = (a_q[PRECISION-2:M] == EMAX) && (a_q[M-1:0] != '0);
        nanB  = (b_q[PRECISION-2:M] == EMAX) && (b_q[M-1:0] != '0);
        infA  = (a_q[PRECISION-2:M] == EMAX) && (a_q[M-1:0] == '0);
        infB  = (b_q[PRECISION-2:M] == EMAX) && (b_q[M-1:0] == '0);
        zeroA = (a_q[PRECISION-2:0] == '0);
        zeroB = (b_q[PRECISION-2:0] == '0);
        aBigger = (a_q[PRECISION-2:0] >= b_q[PRECISION-2:0]);
        expBig = aBigger ? a_q[PRECISION-2:M] : b_q[PRECISION-2:M];
        expSml = aBigger ? b_q[PRECISION-2:M] : a_q[PRECISION-2:M];
        sign_d = aBigger ? a_q[PRECISION-1] : b_q[PRECISION-1];
        effBig = (expBig == '0) ? {{(E-1){1'b0}}, 1'b1} : expBig;
        effSml = (expSml == '0) ? {{(E-1){1'b0}}, 1'b1} : expSml;
        bigExt = {1'b0, expBig != '0, (aBigger ? a_q[M-1:0] : b_q[M-1:0]), 3'b000};
        smlExt = {1'b0, expSml != '0, (aBigger ? b_q[M-1:0] : a_q[M-1:0]), 3'b000};
        shAmt    = effBig - effSml;
        lostMask = ~({W{1'b1}} << shAmt);
        if (32'(shAmt) >= M + 4)
            small_d = {{(W-1){1'b0}}, |smlExt};
        else
            small_d = (smlExt >> shAmt) | {{(W-1){1'b0}}, |(smlExt & lostMask)};

        special_d = 1'b1;
        specVal_d = QNAN;
        if (nanA || nanB)                                      specVal_d = QNAN;
        else if (infA && infB && (a_q[PRECISION-1] != b_q[PRECISION-1])) specVal_d = QNAN;
        else if (infA)                                         specVal_d = a_q;
        else if (infB)                                         specVal_d = b_q;
        else if (zeroA && zeroB)
            specVal_d = {a_q[PRECISION-1] & b_q[PRECISION-1], {(PRECISION-1){1'b0}}};
        else if (zeroA)                                        specVal_d = b_q;
        else if (zeroB)                                        specVal_d = a_q;
        else                                                   special_d = 1'b0;
    end

    // Add/subtract, normalise (exponent floored at 1) and round to nearest even.
    always_comb begin
        sum_d = sub_q ? (sig_q - small_q) : (sig_q + small_q);

        lz     = leadZeros(sig_q[W-2:0]);
        maxSh  = exp_q - 1'b1;
        normSh = (lz < maxSh) ? lz : maxSh;
        if (sig_q[W-1]) begin
            normSig_d = {1'b0, sig_q[W-1:2], sig_q[1] | sig_q[0]};
            normExp_d = exp_q + 1'b1;
        end else begin
            normSig_d = sig_q << normSh;
            normExp_d = exp_q - normSh;
        end

        up     = sig_q[2] & (sig_q[1] | sig_q[0] | sig_q[3]);
        mant   = {1'b0, sig_q[W-2:3]} + {{(M+1){1'b0}}, up};
        rExp   = mant[M+1] ? exp_q + 1'b1 : exp_q;
        frac   = mant[M+1] ? mant[M:1] : mant[M-1:0];
        encExp = (mant[M+1] | mant[M]) ? rExp : '0;
        if (special_q)
            round_d = specVal_q;
        else if (sig_q == '0)
            round_d = '0;
        else if (encExp >= {{(XW-E){1'b0}}, EMAX})
            round_d = {sign_q, EMAX, {M{1'b0}}};
        else
            round_d = {sign_q, encExp[E-1:0], frac};
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            valid_q  <= 1'b0;
            load_q   <= 1'b0;
            armed_q  <= ~Load;
        end else begin
            load_q  <= Load;
            armed_q <= armed_q | ~Load;
            case (state_q)
                IDLE: begin
                    if (Load && !load_q && armed_q) begin
                        a_q     <= A;
                        b_q     <= {B[PRECISION-1] ^ Op, B[PRECISION-2:0]};
                        valid_q <= 1'b0;
                        state_q <= ALIGN;
                    end
                end
                ALIGN: begin
                    sign_q    <= sign_d;
                    sub_q     <= a_q[PRECISION-1] ^ b_q[PRECISION-1];
                    special_q <= special_d;
                    specVal_q <= specVal_d;
                    exp_q     <= {{(XW-E){1'b0}}, effBig};
                    sig_q     <= bigExt;
                    small_q   <= small_d;
                    state_q   <= ADD;
                end
                ADD: begin
                    sig_q   <= sum_d;
                    state_q <= NORM;
                end
                NORM: begin
                    sig_q   <= normSig_d;
                    exp_q   <= normExp_d;
                    state_q <= ROUND;
                end
                ROUND: begin
                    result_q <= round_d;
                    valid_q  <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
